// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid channel between the fetch unit (master) and memory (slave).
// The fetch unit holds at most one request outstanding; gnt and rvalid carry no backpressure of their own.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: one outstanding imem request per PC, fetched word loaded into the IF/ID register.
// Latency: >=2 cycles per instruction; instruction visible on valid_d one edge after rvalid.
// Backpressure: fstall parks a returned word in a one-entry buffer; stop holds the PC until delivery.
module if_fetch_unit #(
    parameter logic [31:0] NOP_INST       = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_i,
    input  logic        flush,
    input  logic        fstall,
    output logic        stop,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_d,
    output logic [31:0] inst_d,
    output logic [31:0] pc_d,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_nx;
    logic [31:0] inst_q, inst_nx;
    logic [31:0] pc_q, pc_nx;

    logic        deliver;
    logic [31:0] dlv_inst;
    logic [31:0] dlv_pc;
    logic        req;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    assign imem_req  = req;
    assign imem_addr = pc_i;
    assign stop      = !deliver && !flush;

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        req        = 1'b0;
        deliver    = 1'b0;
        dlv_inst   = imem_rdata;
        dlv_pc     = req_pc_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                req = !flush;
                if (imem_rvalid && drop_q) drop_d = 1'b0;
                if (imem_gnt && !flush) begin
                    req_pc_d = pc_i;
                    state_d  = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d    = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (fstall) begin
                        buf_inst_d = imem_rdata;
                        buf_pc_d   = req_pc_q;
                        state_d    = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end else begin
                    if (flush) drop_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIM) begin
                        err_d   = 1'b1;
                        drop_d  = 1'b1;
                        state_d = S_REQ;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_REQ;
                end else if (!fstall) begin
                    deliver  = 1'b1;
                    dlv_inst = buf_inst_q;
                    dlv_pc   = buf_pc_q;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_nx = 1'b0;
        inst_nx  = NOP_INST;
        pc_nx    = pc_q;
        if (flush) begin
            valid_nx = 1'b0;
            inst_nx  = NOP_INST;
        end else if (deliver) begin
            valid_nx = 1'b1;
            inst_nx  = dlv_inst;
            pc_nx    = dlv_pc;
        end else if (fstall) begin
            valid_nx = valid_q;
            inst_nx  = inst_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            req_pc_q   <= 32'd0;
            drop_q     <= 1'b0;
            buf_inst_q <= 32'd0;
            buf_pc_q   <= 32'd0;
            valid_q    <= 1'b0;
            inst_q     <= NOP_INST;
            pc_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            valid_q    <= valid_nx;
            inst_q     <= inst_nx;
            pc_q       <= pc_nx;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign valid_d = valid_q;
    assign inst_d  = inst_q;
    assign pc_d    = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected IF/ID deliveries plus per-step output checks.
// Latency: checks combinational outputs mid-cycle and registered outputs one edge later.
// Backpressure: models the PC controller from stop/flush; memory gnt/rvalid driven per step.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_i;
    logic        flush;
    logic        fstall;
    logic        stop;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_d;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic        fetch_err;

    if_fetch_unit #(
        .NOP_INST       (32'h0000_0013),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_i        (pc_i),
        .flush       (flush),
        .fstall      (fstall),
        .stop        (stop),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_d     (valid_d),
        .inst_d      (inst_d),
        .pc_d        (pc_d),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    exp_t        exp_q[$];
    logic [31:0] tgt;
    logic        req_s;
    logic        stop_s;
    logic [31:0] addr_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc   = p;
        e.inst = i;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic fl, input logic fs);
        exp_t e;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        flush       = fl;
        fstall      = fs;
        #2;
        req_s  = imem_req;
        stop_s = stop;
        addr_s = imem_addr;
        @(posedge clk);
        #1;
        if (fl) pc_i = tgt;
        else if (!stop_s) pc_i = pc_i + 32'd4;
        if (!fl && !fs && valid_d) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {31'd0, valid_d}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc_d, e.pc);
                chk("sb_inst", inst_d, e.inst);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        tgt         = 32'd0;
        rstn        = 1'b0;
        pc_i        = 32'd0;
        flush       = 1'b0;
        fstall      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_inst", inst_d, NOP);
        chk("rst_pc", pc_d, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_stop", {31'd0, stop}, 32'd1);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        rstn = 1'b1;

        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("idle_req", {31'd0, req_s}, 32'd0);
        chk("idle_stop", {31'd0, stop_s}, 32'd1);

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req0_req", {31'd0, req_s}, 32'd1);
        chk("req0_addr", addr_s, 32'd0);
        push(32'd0, 32'h0050_0093);
        cyc(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
        chk("rv0_stop", {31'd0, stop_s}, 32'd0);
        chk("rv0_valid", {31'd0, valid_d}, 32'd1);
        chk("rv0_inst", inst_d, 32'h0050_0093);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req4_addr", addr_s, 32'd4);
        chk("bubble_valid", {31'd0, valid_d}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("wait_stop", {31'd0, stop_s}, 32'd1);
        push(32'd4, 32'h0010_0013);
        cyc(1'b0, 1'b1, 32'h0010_0013, 1'b0, 1'b0);

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req8_addr", addr_s, 32'd8);
        push(32'd8, 32'h00A0_0113);
        cyc(1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b1);
        chk("stallrv_stop", {31'd0, stop_s}, 32'd1);
        repeat (3) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            chk("hold_stop", {31'd0, stop_s}, 32'd1);
            chk("hold_req", {31'd0, req_s}, 32'd0);
            chk("hold_valid", {31'd0, valid_d}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("unhold_stop", {31'd0, stop_s}, 32'd0);
        chk("unhold_inst", inst_d, 32'h00A0_0113);
        chk("unhold_pc", pc_d, 32'd8);

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req12_addr", addr_s, 32'd12);
        tgt = 32'h40;
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("flw_stop", {31'd0, stop_s}, 32'd0);
        chk("flw_valid", {31'd0, valid_d}, 32'd0);
        chk("flw_pc_hold", pc_d, 32'd8);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("flw_wait_req", {31'd0, req_s}, 32'd0);
        cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("drop_stop", {31'd0, stop_s}, 32'd1);
        chk("drop_inst", inst_d, NOP);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req40_req", {31'd0, req_s}, 32'd1);
        chk("req40_addr", addr_s, 32'h40);

        tgt = 32'h80;
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("flgnt_req", {31'd0, req_s}, 32'd0);
        chk("flgnt_stop", {31'd0, stop_s}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req80_req", {31'd0, req_s}, 32'd1);
        chk("req80_addr", addr_s, 32'h80);

        tgt = 32'hC0;
        cyc(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);
        chk("flrv_stop", {31'd0, stop_s}, 32'd0);
        chk("flrv_valid", {31'd0, valid_d}, 32'd0);
        chk("flrv_inst", inst_d, NOP);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reqC0_req", {31'd0, req_s}, 32'd1);
        chk("reqC0_addr", addr_s, 32'hC0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("wstall_req", {31'd0, req_s}, 32'd0);
        chk("wstall_stop", {31'd0, stop_s}, 32'd1);
        push(32'hC0, 32'h00C0_0193);
        cyc(1'b0, 1'b1, 32'h00C0_0193, 1'b0, 1'b0);
        chk("rvC0_stop", {31'd0, stop_s}, 32'd0);

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reqC4_addr", addr_s, 32'hC4);
        cyc(1'b0, 1'b1, 32'h00D0_0213, 1'b0, 1'b1);
        tgt = 32'h100;
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("flhold_stop", {31'd0, stop_s}, 32'd0);
        chk("flhold_valid", {31'd0, valid_d}, 32'd0);
        chk("flhold_inst", inst_d, NOP);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req100_addr", addr_s, 32'h100);

`ifdef FETCH_TIMEOUT_EN
        repeat (3) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            chk("to_err_early", {31'd0, fetch_err}, 32'd0);
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("to_err_set", {31'd0, fetch_err}, 32'd1);
        cyc(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0);
        chk("to_retry_req", {31'd0, req_s}, 32'd1);
        chk("to_retry_addr", addr_s, 32'h100);
        chk("to_late_stop", {31'd0, stop_s}, 32'd1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("to_regrant_addr", addr_s, 32'h100);
        push(32'h100, 32'h00E0_0293);
        cyc(1'b0, 1'b1, 32'h00E0_0293, 1'b0, 1'b0);
        chk("to_dlv_stop", {31'd0, stop_s}, 32'd0);
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
`else
        push(32'h100, 32'h00E0_0293);
        cyc(1'b0, 1'b1, 32'h00E0_0293, 1'b0, 1'b0);
        chk("rv100_stop", {31'd0, stop_s}, 32'd0);
        chk("no_err", {31'd0, fetch_err}, 32'd0);
`endif

        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("req104_addr", addr_s, 32'h104);
        rstn = 1'b0;
        #2;
        chk("mrst_valid", {31'd0, valid_d}, 32'd0);
        chk("mrst_pc", pc_d, 32'd0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("mrst_idle_req", {31'd0, req_s}, 32'd0);
        chk("mrst_idle_stop", {31'd0, stop_s}, 32'd1);
        chk("mrst_ign_valid", {31'd0, valid_d}, 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("mrst_req_again", {31'd0, req_s}, 32'd1);
        chk("mrst_req_addr", addr_s, 32'h104);
        chk("mrst_inst", inst_d, NOP);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
